// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// Signal suffixes are from the divider's point of view.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             Start_i;
  logic             Signed_i;
  logic [WIDTH-1:0] Dividend_i;
  logic [WIDTH-1:0] Divisor_i;
  logic             Ready_o;
  logic             Valid_o;
  logic             Ready_i;
  logic [WIDTH-1:0] Quotient_o;
  logic [WIDTH-1:0] Remainder_o;
  logic             DivZero_o;
  logic             Overflow_o;

  // divider side
  modport slave (
    input  Start_i, Signed_i, Dividend_i, Divisor_i, Ready_i,
    output Ready_o, Valid_o, Quotient_o, Remainder_o, DivZero_o, Overflow_o
  );

  // requester / consumer side
  modport master (
    output Start_i, Signed_i, Dividend_i, Divisor_i, Ready_i,
    input  Ready_o, Valid_o, Quotient_o, Remainder_o, DivZero_o, Overflow_o
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// Signed operands are reduced to magnitudes on accept and the signs are
// reapplied in a single fix-up cycle before the result is presented.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;      // dividend magnitude, becomes the quotient as bits shift in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_pend;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dz_q;
  logic             ov_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH:0]   diff;
  logic             is_ovf;

  // operand magnitudes and one restoring step; the extra subtract bit is the borrow
  always_comb begin
    a_neg  = bus.Signed_i & bus.Dividend_i[WIDTH-1];
    b_neg  = bus.Signed_i & bus.Divisor_i[WIDTH-1];
    abs_a  = a_neg ? (~bus.Dividend_i + 1'b1) : bus.Dividend_i;
    abs_b  = b_neg ? (~bus.Divisor_i + 1'b1) : bus.Divisor_i;
    is_ovf = bus.Signed_i
           & (bus.Dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
           & (bus.Divisor_i == {WIDTH{1'b1}});
    r_sh   = {rem[WIDTH-2:0], dvd[WIDTH-1]};
    diff   = {1'b0, r_sh} - {1'b0, dvs};
  end

  // control FSM plus datapath and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      ovf_pend <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.Start_i) begin
          if (bus.Divisor_i == '0) begin
            // divide by zero bypasses the datapath entirely
            quo_q <= '1;
            rem_q <= bus.Dividend_i;
            dz_q  <= 1'b1;
            ov_q  <= 1'b0;
            state <= DONE;
          end else begin
            dvd      <= abs_a;
            dvs      <= abs_b;
            rem      <= '0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            ovf_pend <= is_ovf;
            cnt      <= CW'(WIDTH);
            state    <= CALC;
          end
        end
        CALC: begin
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= r_sh;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quo_q <= q_neg ? (~dvd + 1'b1) : dvd;
          rem_q <= r_neg ? (~rem + 1'b1) : rem;
          dz_q  <= 1'b0;
          ov_q  <= ovf_pend;
          state <= DONE;
        end
        DONE: if (bus.Ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Ready_o     = (state == IDLE);
  assign bus.Valid_o     = (state == DONE);
  assign bus.Quotient_o  = quo_q;
  assign bus.Remainder_o = rem_q;
  assign bus.DivZero_o   = dz_q;
  assign bus.Overflow_o  = ov_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vectors with literal expectations, plus a
// transaction-level reference model checked against the DUT every cycle.
module tb_seq_divider;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // arithmetic reference: what the result must be, from the operands alone
  function automatic res_t ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t o;
    logic signed [W-1:0] sa, sb;
    o = '0;
    sa = a;
    sb = b;
    if (b == '0) begin
      o.q = '1; o.r = a; o.dz = 1'b1;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      o.q = a; o.r = '0; o.ov = 1'b1;
    end else if (sg) begin
      o.q = sa / sb; o.r = sa % sb;
    end else begin
      o.q = a / b; o.r = a % b;
    end
    return o;
  endfunction

  // transaction model: idle / busy for a fixed latency / holding a result
  logic m_idle, m_valid;
  int   m_wait;
  res_t m_pend, m_out;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_wait <= 0; m_pend <= '0; m_out <= '0;
    end else if (m_idle) begin
      if (bus.Start_i) begin
        m_idle <= 1'b0;
        if (bus.Divisor_i == '0) begin
          m_out   <= ref_div(bus.Signed_i, bus.Dividend_i, bus.Divisor_i);
          m_valid <= 1'b1;
        end else begin
          m_pend <= ref_div(bus.Signed_i, bus.Dividend_i, bus.Divisor_i);
          m_wait <= W + 1;
        end
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        m_out   <= m_pend;
      end
    end else if (m_valid && bus.Ready_i) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    nvec++;
    if ({bus.Ready_o, bus.Valid_o, bus.Quotient_o, bus.Remainder_o, bus.DivZero_o, bus.Overflow_o}
        !== {m_idle, m_valid, m_out}) begin
      nerr++;
      $display("FAIL cycle t=%0t: rdy=%b vld=%b q=%h r=%h dz=%b ov=%b, model rdy=%b vld=%b q=%h r=%h dz=%b ov=%b",
               $time, bus.Ready_o, bus.Valid_o, bus.Quotient_o, bus.Remainder_o, bus.DivZero_o,
               bus.Overflow_o, m_idle, m_valid, m_out.q, m_out.r, m_out.dz, m_out.ov);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // one request; hold = cycles of back-pressure in DONE; poke = stray Start pulses
  task automatic do_req(input string name, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input res_t exp, input int hold, input bit poke);
    int lat;
    @(negedge clk);
    bus.Ready_i    = (hold == 0);
    bus.Start_i    = 1'b1;
    bus.Signed_i   = sg;
    bus.Dividend_i = a;
    bus.Divisor_i  = b;
    @(negedge clk);
    bus.Start_i    = 1'b0;
    bus.Dividend_i = $urandom;
    bus.Divisor_i  = $urandom;
    lat = 0;
    while (!bus.Valid_o && lat < 100) begin
      if (poke && lat == 5) begin
        bus.Start_i = 1'b1; bus.Dividend_i = 32'd77; bus.Divisor_i = 32'd1;
      end
      @(negedge clk);
      bus.Start_i = 1'b0;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " q"}, 64'(bus.Quotient_o), 64'(exp.q));
    chk({name, " r"}, 64'(bus.Remainder_o), 64'(exp.r));
    chk({name, " flags"}, 64'({bus.DivZero_o, bus.Overflow_o}), 64'({exp.dz, exp.ov}));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.Start_i = poke && (i == 0);
        @(negedge clk);
      end
      bus.Start_i = 1'b0;
      chk({name, " held vld"}, 64'(bus.Valid_o), 64'd1);
      chk({name, " held q"}, 64'(bus.Quotient_o), 64'(exp.q));
      chk({name, " held r"}, 64'(bus.Remainder_o), 64'(exp.r));
      bus.Ready_i = 1'b1;
    end
    @(negedge clk);
    chk({name, " ready after hs"}, 64'({bus.Ready_o, bus.Valid_o}), 64'b10);
  endtask

  function automatic res_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz, input logic ov);
    res_t o;
    o.q = q; o.r = r; o.dz = dz; o.ov = ov;
    return o;
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    bus.Start_i = 1'b0; bus.Signed_i = 1'b0; bus.Dividend_i = '0; bus.Divisor_i = '0; bus.Ready_i = 1'b1;
    #1;
    chk("reset outputs", 64'({bus.Ready_o, bus.Valid_o, bus.DivZero_o, bus.Overflow_o}), 64'b1000);
    chk("reset q|r", 64'({bus.Quotient_o, bus.Remainder_o}), 64'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;

    do_req("u100/7",     1'b0, 32'd100,        32'd7,          33, mk(32'd14, 32'd2, 0, 0), 0, 0);
    do_req("s-7/2",      1'b1, 32'hFFFF_FFF9,  32'd2,          33, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0), 0, 0);
    do_req("s7/-2",      1'b1, 32'd7,          32'hFFFF_FFFE,  33, mk(32'hFFFF_FFFD, 32'd1, 0, 0), 0, 0);
    do_req("umax/1",     1'b0, 32'hFFFF_FFFF,  32'd1,          33, mk(32'hFFFF_FFFF, 32'd0, 0, 0), 0, 0);
    do_req("u5/0",       1'b0, 32'd5,          32'd0,           0, mk(32'hFFFF_FFFF, 32'd5, 1, 0), 0, 0);
    do_req("s5/0",       1'b1, 32'd5,          32'd0,           0, mk(32'hFFFF_FFFF, 32'd5, 1, 0), 0, 0);
    do_req("s ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  33, mk(32'h8000_0000, 32'd0, 0, 1), 0, 0);
    do_req("u minneg",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  33, mk(32'd0, 32'h8000_0000, 0, 0), 0, 0);
    do_req("u0/5",       1'b0, 32'd0,          32'd5,          33, mk(32'd0, 32'd0, 0, 0), 0, 0);
    do_req("u3/10",      1'b0, 32'd3,          32'd10,         33, mk(32'd0, 32'd3, 0, 0), 0, 0);
    do_req("s-100/-7",   1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  33, mk(32'd14, 32'hFFFF_FFFE, 0, 0), 0, 0);
    do_req("bp 1000/3",  1'b0, 32'd1000,       32'd3,          33, mk(32'd333, 32'd1, 0, 0), 10, 1);

    // a few more operand patterns, expectations from the arithmetic reference
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      do_req("mix", i[0], ra, rb, 33, ref_div(i[0], ra, rb), 0, 0);
    end

    // asynchronous reset in the middle of a computation
    @(negedge clk);
    bus.Start_i = 1'b1; bus.Signed_i = 1'b0; bus.Dividend_i = 32'd12345; bus.Divisor_i = 32'd11;
    @(negedge clk);
    bus.Start_i = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid reset rdy/vld", 64'({bus.Ready_o, bus.Valid_o}), 64'b10);
    chk("mid reset outs", 64'({bus.Quotient_o, bus.Remainder_o, bus.DivZero_o, bus.Overflow_o}), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    do_req("post-rst 100/7", 1'b0, 32'd100, 32'd7, 33, mk(32'd14, 32'd2, 0, 0), 0, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
